axi_10g_ethernet_0_sync_filter_block: RTL and testbench

Multi-channel destination-side synchronizer for quasi-static control and status bits entering the MAC core clock domain, such as link status, PCS lock and pause requests. Each channel has a parametrised flop chain, an optional per-channel glitch filter that requires N consecutive stable cycles, and registered rising/falling edge pulses. It replaces banks of single-bit synchronizers wherever downstream logic needs debounced levels or edge events.

---
 rtl/axi_10g_ethernet_0_sync_filter_block.sv | 152 +++++++++++++++
 tb/tb_axi_10g_ethernet_0_sync_filter_block.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_10g_ethernet_0_sync_filter_block.sv
// axi_10g_ethernet_0_sync_filter_block
//
// Multi-channel synchronizer for quasi-static control/status bits entering the
// MAC core clock domain. Each channel goes through its own flop chain, an
// optional glitch filter, and registered rise/fall edge detection.
//
// Parameters:
//   C_WIDTH          number of independent channels (1..32)
//   C_NUM_SYNC_REGS  synchronizer depth per channel (2..8)
//   C_FILTER_CYCLES  consecutive stable cycles before data_out follows (0 = bypass)
//   C_RESET_VAL      reset value of the sync chains and data_out
//
// Ports:
//   clk         destination clock, rising edge
//   aresetn     asynchronous active-low reset (deassert synchronously to clk)
//   data_in     asynchronous per-channel inputs
//   data_out    synchronized, filtered levels
//   rise_pulse  one-cycle pulse per channel on a data_out 0->1 transition
//   fall_pulse  one-cycle pulse per channel on a data_out 1->0 transition
//   change      OR of all rise/fall pulses, same cycle as the pulses
//
// Build option: define AXI_10G_SYNC_EDGE_DETECT_EN to build the edge
// detectors; without it rise_pulse, fall_pulse and change are tied to 0.

(* dont_touch = "true" *)
module axi_10g_ethernet_0_sync_filter_block #(
  parameter int unsigned        C_WIDTH         = 4,
  parameter int unsigned        C_NUM_SYNC_REGS = 5,
  parameter int unsigned        C_FILTER_CYCLES = 0,
  parameter logic [C_WIDTH-1:0] C_RESET_VAL     = '0
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [C_WIDTH-1:0] data_in,
  output logic [C_WIDTH-1:0] data_out,
  output logic [C_WIDTH-1:0] rise_pulse,
  output logic [C_WIDTH-1:0] fall_pulse,
  output logic               change
);

  // Stage 0 is the metastability-exposed capture flop; the last stage is the
  // settled level used by everything downstream.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [C_NUM_SYNC_REGS-1:0][C_WIDTH-1:0] sync_q;
  logic [C_WIDTH-1:0]                      sync_s;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= {C_NUM_SYNC_REGS{C_RESET_VAL}};
    end else begin
      sync_q <= {sync_q[C_NUM_SYNC_REGS-2:0], data_in};
    end
  end

  assign sync_s = sync_q[C_NUM_SYNC_REGS-1];

`ifdef AXI_10G_SYNC_EDGE_DETECT_EN
  // Value about to be shown on data_out and the value currently shown.
  logic [C_WIDTH-1:0] edge_next;
  logic [C_WIDTH-1:0] edge_prev;
`endif

  if (C_FILTER_CYCLES == 0) begin : g_bypass
    assign data_out = sync_s;

`ifdef AXI_10G_SYNC_EDGE_DETECT_EN
    // data_out is already a flop output here, so edges are taken against a
    // one-cycle delayed copy; pulses therefore lag data_out by one cycle.
    logic [C_WIDTH-1:0] dly_q;

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        dly_q <= C_RESET_VAL;
      end else begin
        dly_q <= sync_s;
      end
    end

    assign edge_next = sync_s;
    assign edge_prev = dly_q;
`endif
  end else begin : g_filter
    localparam logic [7:0] CntMax = 8'(C_FILTER_CYCLES - 1);

    logic [C_WIDTH-1:0][7:0] cnt_q, cnt_d;
    logic [C_WIDTH-1:0]      out_q, out_d;

    // Counter tracks how long sync_s has disagreed with data_out; it is
    // cleared on agreement or on commit, so it never passes CntMax.
    always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      for (int i = 0; i < int'(C_WIDTH); i++) begin
        if (sync_s[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          out_d[i] = sync_s[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        out_q <= C_RESET_VAL;
        cnt_q <= '0;
      end else begin
        out_q <= out_d;
        cnt_q <= cnt_d;
      end
    end

    assign data_out = out_q;

`ifdef AXI_10G_SYNC_EDGE_DETECT_EN
    assign edge_next = out_d;
    assign edge_prev = out_q;
`endif
  end

`ifdef AXI_10G_SYNC_EDGE_DETECT_EN
  logic [C_WIDTH-1:0] rise_d, fall_d;
  logic [C_WIDTH-1:0] rise_q, fall_q;
  logic               change_q;

  assign rise_d = edge_next & ~edge_prev;
  assign fall_d = ~edge_next & edge_prev;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= |(rise_d | fall_d);
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign change     = change_q;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign change     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_10g_ethernet_0_sync_filter_block.sv
// Bench for axi_10g_ethernet_0_sync_filter_block. Four instances (S = 3) with
// filter depths 0, 4, 2 and 8 run side by side from one clock and reset; a
// cycle-level reference model predicts every output of every instance.
module tb_axi_10g_ethernet_0_sync_filter_block;

`ifdef AXI_10G_SYNC_EDGE_DETECT_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic       clk;
  logic       aresetn;
  logic [3:0] din  [4];
  logic [3:0] dout [4];
  logic [3:0] rise [4];
  logic [3:0] fall [4];
  logic       chg  [4];

  int unsigned n_cfg  [4] = '{0, 4, 2, 8};
  logic [3:0]  rv_cfg [4] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_pipe [4][3];  // [0] newest sample of data_in, [2] = s
  logic [3:0] m_out  [4];
  logic [3:0] m_prev [4];     // data_out one cycle earlier
  logic [3:0] m_rise [4];
  logic [3:0] m_fall [4];
  logic       m_chg  [4];
  int         m_run  [4][4];  // consecutive cycles s has differed from data_out

  axi_10g_ethernet_0_sync_filter_block #(
    .C_WIDTH(4), .C_NUM_SYNC_REGS(3), .C_FILTER_CYCLES(0), .C_RESET_VAL(4'b0101)
  ) u_n0 (
    .clk(clk), .aresetn(aresetn), .data_in(din[0]), .data_out(dout[0]),
    .rise_pulse(rise[0]), .fall_pulse(fall[0]), .change(chg[0])
  );

  axi_10g_ethernet_0_sync_filter_block #(
    .C_WIDTH(4), .C_NUM_SYNC_REGS(3), .C_FILTER_CYCLES(4), .C_RESET_VAL(4'b0000)
  ) u_n4 (
    .clk(clk), .aresetn(aresetn), .data_in(din[1]), .data_out(dout[1]),
    .rise_pulse(rise[1]), .fall_pulse(fall[1]), .change(chg[1])
  );

  axi_10g_ethernet_0_sync_filter_block #(
    .C_WIDTH(4), .C_NUM_SYNC_REGS(3), .C_FILTER_CYCLES(2), .C_RESET_VAL(4'b0000)
  ) u_n2 (
    .clk(clk), .aresetn(aresetn), .data_in(din[2]), .data_out(dout[2]),
    .rise_pulse(rise[2]), .fall_pulse(fall[2]), .change(chg[2])
  );

  axi_10g_ethernet_0_sync_filter_block #(
    .C_WIDTH(4), .C_NUM_SYNC_REGS(3), .C_FILTER_CYCLES(8), .C_RESET_VAL(4'b0000)
  ) u_n8 (
    .clk(clk), .aresetn(aresetn), .data_in(din[3]), .data_out(dout[3]),
    .rise_pulse(rise[3]), .fall_pulse(fall[3]), .change(chg[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) m_pipe[k][j] = rv_cfg[k];
      m_out[k]  = rv_cfg[k];
      m_prev[k] = rv_cfg[k];
      m_rise[k] = 4'b0000;
      m_fall[k] = 4'b0000;
      m_chg[k]  = 1'b0;
      for (int i = 0; i < 4; i++) m_run[k][i] = 0;
    end
  endtask

  // One clock edge: data_in reaches s three edges after it is sampled;
  // with a filter, data_out adopts s once s has disagreed for N edges in a row.
  task automatic model_edge();
    logic [3:0] s_pre;
    logic [3:0] old_out;
    for (int k = 0; k < 4; k++) begin
      s_pre = m_pipe[k][2];
      m_pipe[k][2] = m_pipe[k][1];
      m_pipe[k][1] = m_pipe[k][0];
      m_pipe[k][0] = din[k];
      old_out = m_out[k];
      if (n_cfg[k] == 0) begin
        m_out[k]  = m_pipe[k][2];
        m_rise[k] = old_out & ~m_prev[k];
        m_fall[k] = ~old_out & m_prev[k];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (s_pre[i] == old_out[i]) begin
            m_run[k][i] = 0;
          end else begin
            m_run[k][i]++;
            if (m_run[k][i] == int'(n_cfg[k])) begin
              m_out[k][i] = s_pre[i];
              m_run[k][i] = 0;
            end
          end
        end
        m_rise[k] = m_out[k] & ~old_out;
        m_fall[k] = ~m_out[k] & old_out;
      end
      m_prev[k] = old_out;
      if (!EdgeEn) begin
        m_rise[k] = 4'b0000;
        m_fall[k] = 4'b0000;
      end
      m_chg[k] = |(m_rise[k] | m_fall[k]);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.u%0d.data_out", tag, k), dout[k], m_out[k]);
      check($sformatf("%s.u%0d.rise", tag, k), rise[k], m_rise[k]);
      check($sformatf("%s.u%0d.fall", tag, k), fall[k], m_fall[k]);
      check($sformatf("%s.u%0d.change", tag, k), {3'b000, chg[k]}, {3'b000, m_chg[k]});
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!aresetn) model_reset();
    else model_edge();
    #1;
    compare_all(tag);
  endtask

  // Called just after a step; asserts reset mid-cycle, checks at once,
  // holds for two edges and releases on a falling edge.
  task automatic async_reset(input string tag);
    #2 aresetn = 1'b0;
    model_reset();
    #1 compare_all(tag);
    step(tag);
    step(tag);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    int rise_cnt;
    int rate;
    aresetn = 1'b0;
    din[0] = 4'b0101;
    din[1] = 4'b0000;
    din[2] = 4'b0000;
    din[3] = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all("reset");
    check("reset.u0.data_out_const", dout[0], 4'b0101);

    // Reset and hold
    @(negedge clk);
    aresetn = 1'b1;
    din[2] = 4'b0011;
    for (int c = 0; c < 50; c++) begin
      step("hold");
      check("hold.u0.data_out_const", dout[0], 4'b0101);
      check("hold.u0.pulses_const", rise[0] | fall[0], 4'b0000);
    end

    // Latency (N=4, ch0), bypass (N=0, ch3), simultaneous (N=2) together
    din[1] = 4'b0001;
    din[0] = 4'b1101;
    din[2] = 4'b1100;
    for (int e = 1; e <= 8; e++) begin
      step("dir");
      check($sformatf("lat.e%0d.data_out0", e), {3'b000, dout[1][0]}, (e >= 7) ? 4'd1 : 4'd0);
      check($sformatf("lat.e%0d.rise0", e), {3'b000, rise[1][0]},
            {3'b000, (e == 7) ? EdgeEn : 1'b0});
      check($sformatf("lat.e%0d.change", e), {3'b000, chg[1]},
            {3'b000, (e == 7) ? EdgeEn : 1'b0});
      check($sformatf("byp.e%0d.data_out3", e), {3'b000, dout[0][3]}, (e >= 3) ? 4'd1 : 4'd0);
      check($sformatf("byp.e%0d.rise3", e), {3'b000, rise[0][3]},
            {3'b000, (e == 4) ? EdgeEn : 1'b0});
      check($sformatf("sim.e%0d.data_out", e), dout[2], (e >= 5) ? 4'b1100 : 4'b0011);
      check($sformatf("sim.e%0d.rise", e), rise[2], (e == 5 && EdgeEn) ? 4'b1100 : 4'b0000);
      check($sformatf("sim.e%0d.fall", e), fall[2], (e == 5 && EdgeEn) ? 4'b0011 : 4'b0000);
      check($sformatf("sim.e%0d.change", e), {3'b000, chg[2]},
            {3'b000, (e == 5) ? EdgeEn : 1'b0});
    end

    // Glitch reject: ch2 of the N=4 instance high for three cycles
    din[1] = 4'b0101;
    repeat (3) step("glitch");
    din[1] = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      step("glitch");
      check("glitch.data_out2", {3'b000, dout[1][2]}, 4'd0);
      check("glitch.rise2", {3'b000, rise[1][2]}, 4'd0);
    end

    // Reset mid-filter on the N=8 instance, ch1
    din[3] = 4'b0010;
    for (int e = 1; e <= 6; e++) step("rmid");
    async_reset("rmid_rst");
    check("rmid.rst.data_out", dout[3], 4'b0000);
    check("rmid.rst.u0.data_out", dout[0], 4'b0101);
    check("rmid.rst.change", {3'b000, chg[3]}, 4'd0);
    rise_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      step("rmid");
      if (rise[3][1] === 1'b1) rise_cnt++;
      check($sformatf("rmid.e%0d.data_out1", e), {3'b000, dout[3][1]}, (e >= 11) ? 4'd1 : 4'd0);
    end
    check("rmid.rise_count", 4'(rise_cnt), {3'b000, EdgeEn});

    // Randomized traffic with varying toggle density and occasional resets
    for (int c = 0; c < 900; c++) begin
      rate = (c < 300) ? 3 : ((c < 600) ? 9 : 16);
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(rate) == 0) din[k][i] = ~din[k][i];
        end
      end
      step("rand");
      if (c % 200 == 111) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
